// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Frame parser sitting behind the UART receiver, in the baud_clk domain.
//   It hunts for HEADER, then collects address, length, payload and checksum
//   bytes. A frame whose checksum matches is held as a command on a
//   valid/ready handshake. The payload stays readable through rd_idx/rd_data
//   while the command is held.
//
// Ports
//   baud_clk     sampling clock shared with the UART receiver
//   rst          synchronous active-high reset
//   rx_data      received byte
//   rx_rcvd      received flag (level; one byte per rising edge)
//   rx_frameerr  stop-bit error for the current byte
//   rx_dataerr   parity error for the current byte
//   cmd_valid    command available (held until cmd_ready)
//   cmd_ready    consumer accepts the command
//   cmd_addr     command address byte
//   cmd_len      payload byte count
//   rd_idx       payload read index
//   rd_data      payload byte at rd_idx, 0 when rd_idx >= cmd_len
//   err_chk      one-cycle pulse: checksum mismatch
//   err_frame    one-cycle pulse: UART frame/parity error inside a frame
//   err_len      one-cycle pulse: length field above MAX_LEN
//   err_tmo      one-cycle pulse: inter-byte timeout inside a frame
//   err_ovf      one-cycle pulse: byte dropped while a command is held
//   busy         high whenever the parser is not idle
module uart_cmd_parser #(
    parameter logic [7:0] HEADER  = 8'hAA,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 2048,
    parameter int         CNT_W   = 12
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rcvd,
    input  logic       rx_frameerr,
    input  logic       rx_dataerr,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_len,
    input  logic [7:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       err_chk,
    output logic       err_frame,
    output logic       err_len,
    output logic       err_tmo,
    output logic       err_ovf,
    output logic       busy
);

    localparam int             IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             BUF_D     = 1 << IDX_W;
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
    // The counter is compared one short of TIMEOUT so the pulse lands exactly
    // TIMEOUT cycles after the last byte strobe.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CHK,
        HOLD
    } state_t;

    state_t           state;
    logic             rx_rcvd_d;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       sum;
    logic [7:0]       ptr;
    logic [7:0]       addr_r;
    logic [7:0]       len_r;
    logic [7:0]       pbuf [0:BUF_D-1];

    logic byte_stb;
    logic byte_bad;
    logic buf_we;

    // One strobe per byte, however long rx_rcvd stays high.
    assign byte_stb = rx_rcvd & ~rx_rcvd_d;
    assign byte_bad = rx_frameerr | rx_dataerr;
    assign buf_we   = byte_stb & ~byte_bad & (state == DATA);

    assign busy    = (state != IDLE);
    assign rd_data = (rd_idx < cmd_len) ? pbuf[rd_idx[IDX_W-1:0]] : 8'h00;

    // Payload storage carries no reset; contents only matter once a frame
    // has been accepted, and nothing writes it outside DATA.
    always_ff @(posedge baud_clk) begin
        if (buf_we) begin
            pbuf[ptr[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_rcvd_d <= 1'b0;
            tmo_cnt   <= '0;
            sum       <= 8'h00;
            ptr       <= 8'h00;
            addr_r    <= 8'h00;
            len_r     <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_addr  <= 8'h00;
            cmd_len   <= 8'h00;
            err_chk   <= 1'b0;
            err_frame <= 1'b0;
            err_len   <= 1'b0;
            err_tmo   <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            rx_rcvd_d <= rx_rcvd;
            err_chk   <= 1'b0;
            err_frame <= 1'b0;
            err_len   <= 1'b0;
            err_tmo   <= 1'b0;
            err_ovf   <= 1'b0;

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    // Corrupted bytes outside a frame are dropped silently.
                    if (byte_stb && !byte_bad && rx_data == HEADER) begin
                        state <= ADDR;
                        sum   <= 8'h00;
                        ptr   <= 8'h00;
                    end
                end

                ADDR, LEN, DATA, CHK: begin
                    if (byte_stb) begin
                        // A byte in the timeout cycle wins over the timeout.
                        tmo_cnt <= '0;
                        if (byte_bad) begin
                            err_frame <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            case (state)
                                ADDR: begin
                                    addr_r <= rx_data;
                                    sum    <= rx_data;
                                    state  <= LEN;
                                end
                                LEN: begin
                                    len_r <= rx_data;
                                    sum   <= sum + rx_data;
                                    if (rx_data > MAX_LEN_B) begin
                                        err_len <= 1'b1;
                                        state   <= IDLE;
                                    end else if (rx_data == 8'h00) begin
                                        state <= CHK;
                                    end else begin
                                        state <= DATA;
                                    end
                                end
                                DATA: begin
                                    ptr <= ptr + 8'd1;
                                    sum <= sum + rx_data;
                                    if (ptr == len_r - 8'd1) begin
                                        state <= CHK;
                                    end
                                end
                                default: begin
                                    if (rx_data == sum) begin
                                        state     <= HOLD;
                                        cmd_valid <= 1'b1;
                                        cmd_addr  <= addr_r;
                                        cmd_len   <= len_r;
                                    end else begin
                                        err_chk <= 1'b1;
                                        state   <= IDLE;
                                    end
                                end
                            endcase
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_tmo <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                HOLD: begin
                    tmo_cnt <= '0;
                    // The held command owns the buffer; any new byte is lost,
                    // even one arriving in the handshake cycle.
                    if (byte_stb) begin
                        err_ovf <= 1'b1;
                    end
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
